simpsons_sensor_conditioner: RTL and testbench
==============================================

Name: simpsons_sensor_conditioner

Overview:
Upstream front end for the simpsons_sensor occupancy FSM. It takes the two raw, asynchronous door photo-sensor lines and synchronises each into CLK. It then glitch-filters the 2-bit code as a unit and presents a clean, stable G[1:0] to the FSM's G input. It also flags a sensor that stays blocked too long (stuck beam or person loitering in the doorway).

Parameters:
DEBOUNCE, 1, number of extra consecutive matching synchronised samples needed before a new code is accepted; legal range 1..255
STUCK_CYCLES, 255, number of consecutive cycles with G != 0 that raises FAULT; legal range 1..65535

Ports:
CLK  input  1  system clock, rising-edge
RESET  input  1  synchronous, active-high reset
G_RAW  input  2  raw sensor lines; bit1 = elevated (head) beam, bit0 = lower beam; asynchronous to CLK
G  output  2  filtered sensor code; drives simpsons_sensor.G
G_CHANGE  output  1  one-cycle strobe, high in the cycle G takes a new value
FAULT  output  1  sticky stuck-sensor flag

Behaviour:
- One clock domain, CLK. RESET is synchronous and active-high, sampled on the rising edge of CLK.
- Reset values: sync stages = 0, CAND = 0, CNT = 0, G = 0, G_CHANGE = 0, STUCK_CNT = 0, FAULT = 0.
- Synchroniser: two flops per bit (S1, S2). Both bits use the same stages, so the code moves as a unit.
- Filter state:
  - CAND[1:0] holds the candidate code.
  - CNT is 8 bits and saturating.
  - If S2 != CAND: load CAND <= S2 and CNT <= 0.
  - Else if CAND != G and CNT == DEBOUNCE-1: G <= CAND and G_CHANGE <= 1.
  - Else if CNT < DEBOUNCE-1: CNT <= CNT+1.
  - G_CHANGE is 0 in every other cycle.
- Latency: a raw change held stable appears on G at rising edge DEBOUNCE+3 after the change (2 sync edges, 1 CAND load, DEBOUNCE qualify edges). With DEBOUNCE=1, G updates on the 4th edge.
- Glitch rule:
  - A raw code held for at least DEBOUNCE+1 cycles is always accepted.
  - A code held for DEBOUNCE cycles or fewer never reaches G.
  - G never passes through an intermediate code.
- Return to a previous code before acceptance: CAND reloads and CNT restarts. G is unchanged and no G_CHANGE is produced.
- Same code re-qualified (CAND == G): no strobe, and G is unchanged.
- Codes 0..3 are all legal, including 3 (both beams). 2'b11 is passed through unchanged.
- Stuck detector:
  - STUCK_CNT is 16 bits and counts cycles with G != 0.
  - It clears in any cycle with G == 0.
  - It saturates at STUCK_CYCLES; when STUCK_CNT == STUCK_CYCLES, FAULT <= 1.
  - FAULT is sticky until RESET. Clearing STUCK_CNT does not clear FAULT.
  - G filtering continues normally while FAULT = 1.
- Reset mid-operation: all state returns to reset values on that edge. There is no G_CHANGE in the reset cycle. A raw code present at reset release re-qualifies from scratch, with full DEBOUNCE+3 latency.
- Simultaneous events: RESET has priority over all other updates. A G update and a STUCK_CNT update on the same edge both take effect; STUCK_CNT evaluates the pre-edge G.

Test Plan:
1. RESET=1 for 2 cycles with G_RAW=2'b11 → G=0, G_CHANGE=0, FAULT=0 throughout. After release, G=3 on edge 4 (DEBOUNCE=1).
2. DEBOUNCE=1; G_RAW sequence 1 (2 cyc), 0 (2 cyc) → G goes 0→1→0, each change exactly 4 edges after the raw change, with one G_CHANGE pulse per change.
3. DEBOUNCE=4; 4-cycle pulse G_RAW=2 → G stays 0 and no G_CHANGE. A 5-cycle pulse → G=2 for 5 cycles, starting 7 edges after the rise.
4. DEBOUNCE=1; Homer sequence 2,3,0 (2 cycles each), then Bart sequence 1,0 → G reproduces 2,3,0,1,0 in order, with no other codes and exactly 5 G_CHANGE pulses.
5. STUCK_CYCLES=10; hold G_RAW=1 → FAULT rises exactly 10 cycles after G becomes 1. Set G_RAW=0 → G=0 but FAULT stays 1. RESET → FAULT=0.
6. Assert RESET in the middle of qualifying a new code (CNT=2, DEBOUNCE=4) → G stays at 0 and there is no G_CHANGE. After release, acceptance requires the full 7 edges again.

Source files
------------

// File: rtl/simpsons_sensor_conditioner_if.sv
// Sensor-side bundle: raw door beams in, filtered code, change strobe and stuck flag out.
// The conditioner uses the slave modport; whatever drives the beams uses the master modport.
interface simpsons_sensor_conditioner_if;
   logic [1:0] G_RAW;
   logic [1:0] G;
   logic       G_CHANGE;
   logic       FAULT;

   modport master (output G_RAW, input G, G_CHANGE, FAULT);
   modport slave  (input G_RAW, output G, G_CHANGE, FAULT);
endinterface

// File: rtl/simpsons_sensor_conditioner.sv
// Front end for the simpsons_sensor occupancy FSM: synchronises the two door beams,
// glitch-filters the 2-bit code as a unit and flags a beam that stays blocked too long.
module simpsons_sensor_conditioner #(
   parameter int unsigned DEBOUNCE     = 1,
   parameter int unsigned STUCK_CYCLES = 255
) (
   input  logic                        CLK,
   input  logic                        RESET,
   simpsons_sensor_conditioner_if.slave sif
);

   localparam logic [7:0]  deb_last  = 8'(DEBOUNCE - 1);
   localparam logic [15:0] stuck_max = 16'(STUCK_CYCLES);

   logic [1:0]  s1, s2;
   logic [1:0]  cand;
   logic [7:0]  cnt;
   logic [1:0]  g;
   logic        g_change;
   logic [15:0] stuck_cnt, stuck_nxt;
   logic        fault;

   // Both bits share the same two stages so the code crosses into CLK as a unit.
   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1 <= 2'b00;
         s2 <= 2'b00;
      end else begin
         s1 <= sif.G_RAW;
         s2 <= s1;
      end
   end

   // cnt never exceeds deb_last: it restarts on every reload and only climbs while below it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cand     <= 2'b00;
         cnt      <= 8'd0;
         g        <= 2'b00;
         g_change <= 1'b0;
      end else begin
         g_change <= 1'b0;
         if (s2 != cand) begin
            cand <= s2;
            cnt  <= 8'd0;
         end else if (cand != g && cnt == deb_last) begin
            g        <= cand;
            g_change <= 1'b1;
         end else if (cnt != deb_last) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   // NOTE: every combinational output gets its default first so no latch is inferred.
   always_comb begin
      stuck_nxt = stuck_cnt;
      if (g == 2'b00) begin
         stuck_nxt = 16'd0;
      end else if (stuck_cnt != stuck_max) begin
         stuck_nxt = stuck_cnt + 16'd1;
      end
   end

   // The flag rises on the edge the count reaches its limit and only RESET clears it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         stuck_cnt <= 16'd0;
         fault     <= 1'b0;
      end else begin
         stuck_cnt <= stuck_nxt;
         if (stuck_nxt == stuck_max) begin
            fault <= 1'b1;
         end
      end
   end

   assign sif.G        = g;
   assign sif.G_CHANGE = g_change;
   assign sif.FAULT    = fault;

endmodule

// File: tb/tb_simpsons_sensor_conditioner.sv
// Scoreboard bench: each driven raw code that should qualify queues its code and due cycle;
// the per-cycle monitor pops an entry on every G_CHANGE and compares code and timing.
module tb_simpsons_sensor_conditioner;

   typedef struct packed {
      int unsigned due;
      logic [1:0]  code;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1, rst4;

   simpsons_sensor_conditioner_if if1 ();
   simpsons_sensor_conditioner_if if4 ();

   simpsons_sensor_conditioner #(.DEBOUNCE(1), .STUCK_CYCLES(10)) dut1 (
      .CLK   (clk),
      .RESET (rst1),
      .sif   (if1.slave)
   );

   simpsons_sensor_conditioner #(.DEBOUNCE(4), .STUCK_CYCLES(255)) dut4 (
      .CLK   (clk),
      .RESET (rst4),
      .sif   (if4.slave)
   );

   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          strobes = 0;
   exp_t        exp_q[$];
   logic        sel4 = 1'b0;
   logic [1:0]  model_g = 2'b00;
   logic [1:0]  prev_g = 2'b00;

   logic [1:0] mon_g;
   logic       mon_chg, mon_rst;
   assign mon_g   = sel4 ? if4.G : if1.G;
   assign mon_chg = sel4 ? if4.G_CHANGE : if1.G_CHANGE;
   assign mon_rst = sel4 ? rst4 : rst1;

   // Advance one clock and run the scoreboard monitor on the selected DUT.
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (mon_rst !== 1'b1) begin
         checks++;
         if (mon_chg !== (mon_g !== prev_g)) begin
            errors++;
            $display("FAIL strobe_consistency: G_CHANGE=%b while G went %0d->%0d at cycle %0d",
                     mon_chg, prev_g, mon_g, cyc);
         end
         if (mon_chg === 1'b1) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: G=%0d at cycle %0d, no change expected", mon_g, cyc);
            end else begin
               e = exp_q.pop_front();
               if (e.due !== cyc || e.code !== mon_g) begin
                  errors++;
                  $display("FAIL g_update: got G=%0d at cycle %0d, expected G=%0d at cycle %0d",
                           mon_g, cyc, e.code, e.due);
               end
            end
         end
      end
      prev_g = mon_g;
   endtask

   task automatic set_sel(input logic use4, input logic [1:0] g_now);
      sel4    = use4;
      prev_g  = mon_g;
      model_g = g_now;
   endtask

   // Drive a raw code for n cycles; a code held at least DEBOUNCE+1 cycles is due DEBOUNCE+3 edges later.
   task automatic drive(input logic [1:0] code, input int n);
      int deb;
      exp_t e;
      deb = sel4 ? 4 : 1;
      if (sel4) if4.G_RAW = code;
      else      if1.G_RAW = code;
      if (n >= deb + 1 && code != model_g) begin
         e.due  = cyc + deb + 3;
         e.code = code;
         exp_q.push_back(e);
         model_g = code;
      end
      repeat (n) step();
   endtask

   task automatic wait_drain(input int budget);
      int left;
      left = budget;
      while (exp_q.size() != 0 && left > 0) begin
         step();
         left--;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected G changes never arrived within %0d cycles", exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      exp_t e;
      rst1 = 1'b1;
      rst4 = 1'b1;
      if1.G_RAW = 2'b11;
      if4.G_RAW = 2'b00;
      set_sel(1'b0, 2'b00);
      repeat (2) begin
         step();
         checks++;
         if (if1.G !== 2'b00 || if1.G_CHANGE !== 1'b0 || if1.FAULT !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: G=%0d G_CHANGE=%b FAULT=%b, expected 0/0/0",
                     if1.G, if1.G_CHANGE, if1.FAULT);
         end
      end
      prev_g = mon_g;
      rst1 = 1'b0;
      rst4 = 1'b0;
      e.due  = cyc + 4;
      e.code = 2'b11;
      exp_q.push_back(e);
      model_g = 2'b11;
      repeat (3) step();
      checks++;
      if (if1.G !== 2'b00) begin
         errors++;
         $display("FAIL reset_release_early: G=%0d after 3 edges, expected 0", if1.G);
      end
      wait_drain(10);
      checks++;
      if (if1.G !== 2'b11) begin
         errors++;
         $display("FAIL reset_release_code: G=%0d, expected 3", if1.G);
      end
   endtask

   task automatic test_toggle();
      drive(2'b00, 6);
      wait_drain(10);
      strobes = 0;
      drive(2'b01, 2);
      drive(2'b00, 6);
      wait_drain(10);
      checks++;
      if (strobes != 2 || if1.G !== 2'b00) begin
         errors++;
         $display("FAIL toggle: strobes=%0d G=%0d, expected 2 strobes and G=0", strobes, if1.G);
      end
   endtask

   task automatic test_glitch();
      set_sel(1'b1, 2'b00);
      strobes = 0;
      drive(2'b10, 4);
      drive(2'b00, 12);
      checks++;
      if (strobes != 0 || if4.G !== 2'b00) begin
         errors++;
         $display("FAIL glitch_reject: strobes=%0d G=%0d, expected 0 strobes and G=0", strobes, if4.G);
      end
      drive(2'b10, 5);
      drive(2'b00, 12);
      wait_drain(10);
      checks++;
      if (strobes != 2 || if4.G !== 2'b00) begin
         errors++;
         $display("FAIL glitch_accept: strobes=%0d G=%0d, expected 2 strobes and G=0", strobes, if4.G);
      end
   endtask

   task automatic test_sequence();
      set_sel(1'b0, 2'b00);
      strobes = 0;
      drive(2'b10, 2);
      drive(2'b11, 2);
      drive(2'b00, 2);
      drive(2'b01, 2);
      drive(2'b00, 6);
      wait_drain(10);
      checks++;
      if (strobes != 5 || if1.G !== 2'b00) begin
         errors++;
         $display("FAIL sequence: strobes=%0d G=%0d, expected 5 strobes and G=0", strobes, if1.G);
      end
   endtask

   task automatic test_stuck();
      set_sel(1'b0, 2'b00);
      checks++;
      if (if1.FAULT !== 1'b0) begin
         errors++;
         $display("FAIL stuck_idle: FAULT=%b, expected 0", if1.FAULT);
      end
      // G becomes 1 four edges in; FAULT is due ten edges after that.
      drive(2'b01, 13);
      checks++;
      if (if1.FAULT !== 1'b0) begin
         errors++;
         $display("FAIL stuck_early: FAULT=%b nine cycles after G=1, expected 0", if1.FAULT);
      end
      step();
      checks++;
      if (if1.FAULT !== 1'b1) begin
         errors++;
         $display("FAIL stuck_rise: FAULT=%b ten cycles after G=1, expected 1", if1.FAULT);
      end
      drive(2'b00, 6);
      wait_drain(10);
      checks++;
      if (if1.G !== 2'b00 || if1.FAULT !== 1'b1) begin
         errors++;
         $display("FAIL stuck_sticky: G=%0d FAULT=%b, expected G=0 FAULT=1", if1.G, if1.FAULT);
      end
      rst1 = 1'b1;
      step();
      checks++;
      if (if1.FAULT !== 1'b0 || if1.G !== 2'b00) begin
         errors++;
         $display("FAIL stuck_clear: FAULT=%b G=%0d after reset, expected 0/0", if1.FAULT, if1.G);
      end
      rst1 = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      set_sel(1'b1, 2'b00);
      strobes = 0;
      if4.G_RAW = 2'b10;
      repeat (5) step();
      rst4 = 1'b1;
      step();
      checks++;
      if (if4.G !== 2'b00 || if4.G_CHANGE !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: G=%0d G_CHANGE=%b in reset cycle, expected 0/0", if4.G, if4.G_CHANGE);
      end
      rst4 = 1'b0;
      e.due  = cyc + 7;
      e.code = 2'b10;
      exp_q.push_back(e);
      model_g = 2'b10;
      repeat (6) step();
      checks++;
      if (if4.G !== 2'b00 || strobes != 0) begin
         errors++;
         $display("FAIL reset_mid_early: G=%0d strobes=%0d six edges after release, expected 0/0",
                  if4.G, strobes);
      end
      wait_drain(10);
      checks++;
      if (if4.G !== 2'b10) begin
         errors++;
         $display("FAIL reset_mid_accept: G=%0d, expected 2", if4.G);
      end
      drive(2'b00, 12);
      wait_drain(10);
   endtask

   initial begin
      test_reset();
      test_toggle();
      test_glitch();
      test_sequence();
      test_stuck();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
